// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO: feeder FSM states and default sizing.
package uart_pkg;

    localparam int unsigned UART_TX_FIFO_DEPTH_DEFAULT  = 16;
    localparam int unsigned UART_TX_FIFO_ADDR_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        SEND   = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with registered full/empty/level; head byte is read combinationally.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = UART_TX_FIFO_DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = UART_TX_FIFO_ADDR_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic [7:0]      i_wr_data,
    input  logic            i_pop,
    output logic [7:0]      o_head_c,
    output logic            o_full,
    output logic            o_empty,
    output logic [ADDR_W:0] o_level
);

    localparam int unsigned LVL_W = ADDR_W + 1;

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_full;
    logic              r_empty;
    logic [ADDR_W:0]   w_level_next;
    logic              w_push_ok;
    logic              w_pop_ok;

    // A write into a full FIFO is lost even if a pop frees a slot in the same cycle.
    assign w_push_ok = i_push & ~r_full;
    assign w_pop_ok  = i_pop & ~r_empty;

    // Next occupancy; a simultaneous push and pop cancel out.
    always_comb begin
        w_level_next = r_level;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_level_next = r_level + LVL_W'(1);
            2'b01:   w_level_next = r_level - LVL_W'(1);
            default: w_level_next = r_level;
        endcase
    end

    // Storage write; the array itself is not reset, only the pointers.
    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; flags are registered from the next level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_level <= w_level_next;
            r_full  <= (w_level_next == LVL_W'(DEPTH));
            r_empty <= (w_level_next == '0);
        end
    end

    assign o_head_c = r_mem[r_rd_ptr];
    assign o_full   = r_full;
    assign o_empty  = r_empty;
    assign o_level  = r_level;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a begin/busy handshake.
// Optional feature macro UART_TX_FIFO_OVERFLOW_EN adds a sticky overflow output.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = UART_TX_FIFO_DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = UART_TX_FIFO_ADDR_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [7:0]      wr_data,
    output logic            full,
    output logic            empty,
    output logic [ADDR_W:0] level,
    output logic            tx_begin,
    output logic [7:0]      tx_data,
    input  logic            tx_busy
`ifdef UART_TX_FIFO_OVERFLOW_EN
    ,
    output logic            overflow
`endif
);

    feeder_state_t   r_state;
    feeder_state_t   w_state_next;
    logic            r_tx_begin;
    logic [7:0]      r_tx_data;
    logic            w_pop;
    logic            w_begin_next;
    logic [7:0]      w_head;
    logic            w_full;
    logic            w_empty;
    logic [ADDR_W:0] w_level;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (wr_en),
        .i_wr_data (wr_data),
        .i_pop     (w_pop),
        .o_head_c  (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (w_level)
    );

    // Feeder next-state: pop only when the transmitter is idle, hold data until back in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !tx_busy) begin
                    w_pop        = 1'b1;
                    w_state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                if (tx_busy) begin
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        w_begin_next = (w_state_next == LAUNCH);
    end

    // Feeder state and registered transmitter-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tx_begin <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_state    <= w_state_next;
            r_tx_begin <= w_begin_next;
            if (w_pop) begin
                r_tx_data <= w_head;
            end
        end
    end

    assign tx_begin = r_tx_begin;
    assign tx_data  = r_tx_data;
    assign full     = w_full;
    assign empty    = w_empty;
    assign level    = w_level;

`ifdef UART_TX_FIFO_OVERFLOW_EN
    logic r_overflow;

    // Sticky record of any write dropped because the FIFO was full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (wr_en && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`endif

endmodule
